// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing, bounded memory
// waits with a sticky fault state, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_state;
  logic       waiting;
  logic       timed_out;
  logic       retire;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[WIDTH-1:15], instr[11:7]};

  // Derived from state rather than mem_req to keep the decode free of feedback.
  assign mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign waiting   = mem_state && !mem_ready;
  assign timed_out = waiting && (wait_cnt == WAIT_LAST);

  assign retire = (state_next == FETCH) &&
                  (state inside {MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JAL});

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    alu_op     = 2'd0;
    fault      = 1'b0;

    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd2;
        alu_op     = 2'd0;
        result_src = 2'd2;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (timed_out) begin
          state_next = FAULT;
        end
      end

      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        alu_op    = 2'd0;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEM_ADR;
          OP_RTYPE:          state_next = EXEC_R;
          OP_ITYPE:          state_next = EXEC_I;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default:           state_next = FAULT;
        endcase
      end

      MEM_ADR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        alu_op     = 2'd0;
        state_next = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_next = MEM_WB;
        end else if (timed_out) begin
          state_next = FAULT;
        end
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'd1;
        state_next = FETCH;
      end

      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          state_next = FETCH;
        end else if (timed_out) begin
          state_next = FAULT;
        end
      end

      EXEC_R: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd0;
        alu_op     = 2'd2;
        state_next = ALU_WB;
      end

      EXEC_I: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        alu_op     = 2'd2;
        state_next = ALU_WB;
      end

      ALU_WB: begin
        reg_write  = 1'b1;
        result_src = 2'd0;
        state_next = FETCH;
      end

      BRANCH: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd0;
        alu_op     = 2'd1;
        result_src = 2'd0;
        state_next = FETCH;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: state_next = FAULT;
        endcase
      end

      JAL: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        alu_op     = 2'd0;
        result_src = 2'd0;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end

      FAULT: begin
        fault      = 1'b1;
        state_next = FAULT;
      end

      default: begin
        state_next = FAULT;
      end
    endcase
  end

endmodule
